dcache_mshr: RTL
================

# dcache_mshr

Data-cache miss-status unit: the dcache-side initiator of the main-memory request/response protocol. Tracks up to NUM_MSHR outstanding line misses, issues line reads, store-merge reads and writebacks to main memory under `mem_full` backpressure, and matches returned lines to pending entries by line address. Returned lines are forwarded to the dcache fill path.

## Interface
- `LINE_WORDS`, 4: 32-bit words per cache line (power of 2, ≥2).
- `NUM_MSHR`, 4: miss entries (2..8).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `miss_valid` in 1: dcache presents a miss.
- `miss_addr` in 32: byte address of the miss.
- `miss_store` in 1: the miss is a store.
- `miss_store_data` in 32: store word.
- `miss_ready` out 1: miss accepted this cycle.
- `evict_valid` in 1, `evict_addr` in 32, `evict_data` in LINE_WORDS*32: dirty line to write back.
- `evict_ready` out 1: eviction buffer empty and able to accept.
- `mem_req_valid` out 1, `mem_req_addr` out 32, `mem_req_data` out LINE_WORDS*32, `mem_req_store` out 1, `mem_req_writeback` out 1: request to memory.
- `mem_full` in 1: memory has no free request slot.
- `mem_resp_valid` in 1, `mem_resp_addr` in 32, `mem_resp_data` in LINE_WORDS*32: line returned by memory.
- `fill_valid` out 1, `fill_addr` out 32, `fill_data` out LINE_WORDS*32: line to dcache.
- `resp_err` out 1: sticky, unmatched response seen.

## Operation
- Line address = address with low log2(LINE_WORDS)+2 bits cleared; all matching uses line address.
- Entry states: FREE -> PEND (accepted, not issued) -> WAIT (issued) -> FREE (response matched).
- Entry holds full miss address, store flag, store word.
- Eviction buffer: single entry; loaded on `evict_valid && evict_ready`; cleared when its writeback is issued.
- `miss_ready` = free entry exists AND miss line ≠ eviction-buffer line (while valid) AND miss line ≠ line of `mem_resp_addr` while `mem_resp_valid` AND merge rule permits. Depends combinationally on `miss_addr`/`miss_store`.
- Merge rule: load miss whose line matches a PEND/WAIT entry is accepted without allocating; the entry's fill serves it. Store miss matching an active line: `miss_ready`=0.
- Allocation: lowest-index FREE entry.
- Issue select: eviction buffer first, else lowest-index PEND entry. `mem_req_valid` = selection exists; fields driven combinationally from registered state and held stable until transfer.
- Transfer when `mem_req_valid && !mem_full` at a posedge; selected entry -> WAIT (writeback: buffer cleared).
- Writeback request: `mem_req_writeback`=1, `mem_req_store`=0, `mem_req_data`=`evict_data`, addr = `evict_addr`; no response expected.
- Store-miss request: `mem_req_store`=1, `mem_req_addr`=full miss address (word offset selects merge position), `mem_req_data[31:0]`=store word, upper bits 0.
- Load request: both flags 0, data 0, addr = miss address.
- Response: `mem_resp_valid` with line matching a WAIT entry -> entry FREE, fill registered. No matching WAIT entry -> dropped, `resp_err` set until reset.

## Timing
- Reset: all entries FREE, buffer empty; `fill_valid`, `resp_err`, `mem_req_valid` = 0; `fill_addr`/`fill_data` = 0; `miss_ready`/`evict_ready` reflect empty state (1 when inputs permit).
- Earliest issue: cycle after acceptance (no issue in the accept cycle).
- `fill_valid` pulses exactly one cycle, the cycle after `mem_resp_valid`; `fill_addr` is line-aligned; entry FREE from that same cycle, reusable for an acceptance in it.
- One request transfer and one response per cycle maximum; acceptance, issue and response may all occur in one cycle on different entries.
- All entries busy: `miss_ready`=0 until a response frees one.
- `mem_full` held high: request fields stable, no state change.
- `rst` mid-operation: all in-flight entries discarded; late responses after reset set `resp_err`.

## Configuration
- `DCACHE_MSHR_MERGE_EN` defined: load-to-active-line merging as above.
- Undefined: any miss (load or store) whose line matches a PEND/WAIT entry gets `miss_ready`=0 until that entry frees.

## Test plan
- Load miss 0x0000_0104, `mem_full`=0 -> next cycle request addr 0x104, flags 0; response addr 0x100 data D -> next cycle `fill_valid`=1, `fill_addr`=0x100, data D.
- Store miss 0x208 word 0xDEADBEEF -> request `mem_req_store`=1, addr 0x208, data[31:0]=0xDEADBEEF, upper bits 0.
- Evict 0x300 plus load miss 0x400 same cycle -> writeback issued first, load next; load miss 0x304 stalled while buffer holds 0x300.
- Four misses to distinct lines with `mem_full`=1 -> fifth miss `miss_ready`=0; release `mem_full` -> issues in index order 0..3.
- Response addr 0x700 with no WAIT entry -> no fill, `resp_err`=1 persisting until `rst`.
- With merge on: loads 0x100 and 0x10C -> single request, single fill; merge off -> second load stalls until fill.

Source files
------------

// File: rtl/dcache_mshr.sv
// dcache_mshr: data-cache miss-status unit. Tracks outstanding line misses,
// issues reads / store-merge reads / writebacks to main memory and matches
// returned lines back to waiting entries by line address.
// Optional feature: define DCACHE_MSHR_MERGE_EN to let load misses to an
// already-active line piggy-back on that entry instead of stalling.
module dcache_mshr #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_MSHR   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_valid,
  input  logic [31:0]                miss_addr,
  input  logic                       miss_store,
  input  logic [31:0]                miss_store_data,
  output logic                       miss_ready,
  input  logic                       evict_valid,
  input  logic [31:0]                evict_addr,
  input  logic [LINE_WORDS*32-1:0]   evict_data,
  output logic                       evict_ready,
  output logic                       mem_req_valid,
  output logic [31:0]                mem_req_addr,
  output logic [LINE_WORDS*32-1:0]   mem_req_data,
  output logic                       mem_req_store,
  output logic                       mem_req_writeback,
  input  logic                       mem_full,
  input  logic                       mem_resp_valid,
  input  logic [31:0]                mem_resp_addr,
  input  logic [LINE_WORDS*32-1:0]   mem_resp_data,
  output logic                       fill_valid,
  output logic [31:0]                fill_addr,
  output logic [LINE_WORDS*32-1:0]   fill_data,
  output logic                       resp_err
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
  localparam int LINE_W = LINE_WORDS * 32;
  localparam int IDX_W  = $clog2(NUM_MSHR);
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFF_W) - 32'd1);

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]        st_q    [NUM_MSHR];
  logic [1:0]        st_d    [NUM_MSHR];
  logic [31:0]       addr_q  [NUM_MSHR];
  logic [31:0]       addr_d  [NUM_MSHR];
  logic              store_q [NUM_MSHR];
  logic              store_d [NUM_MSHR];
  logic [31:0]       sdata_q [NUM_MSHR];
  logic [31:0]       sdata_d [NUM_MSHR];
  logic              ev_valid_q, ev_valid_d;
  logic [31:0]       ev_addr_q, ev_addr_d;
  logic [LINE_W-1:0] ev_data_q, ev_data_d;
  logic              fill_valid_q, fill_valid_d;
  logic [31:0]       fill_addr_q, fill_addr_d;
  logic [LINE_W-1:0] fill_data_q, fill_data_d;
  logic              resp_err_q, resp_err_d;

  logic             free_found, pend_found, active_hit, resp_hit, merge_ok, alloc, xfer;
  logic [IDX_W-1:0] free_idx, pend_idx, resp_idx;

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return a & LINE_MASK;
  endfunction

  // Scan entries: lowest free / lowest pending slot, active-line and response matches.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    pend_found = 1'b0;
    pend_idx   = '0;
    active_hit = 1'b0;
    resp_hit   = 1'b0;
    resp_idx   = '0;
    for (int i = NUM_MSHR - 1; i >= 0; i--) begin
      if (st_q[i] == ST_FREE) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (st_q[i] == ST_PEND) begin
        pend_found = 1'b1;
        pend_idx   = IDX_W'(i);
      end
      if (st_q[i] != ST_FREE && line_of(addr_q[i]) == line_of(miss_addr))
        active_hit = 1'b1;
      if (st_q[i] == ST_WAIT && line_of(addr_q[i]) == line_of(mem_resp_addr)) begin
        resp_hit = 1'b1;
        resp_idx = IDX_W'(i);
      end
    end
  end

`ifdef DCACHE_MSHR_MERGE_EN
  // A load to an in-flight line is served by that entry's fill; stores still stall.
  assign merge_ok = !active_hit || !miss_store;
`else
  assign merge_ok = !active_hit;
`endif

  // A miss to the line sitting in the eviction buffer or arriving this cycle would
  // race the data it needs, so it waits.
  assign miss_ready = free_found
                   && !(ev_valid_q && line_of(miss_addr) == line_of(ev_addr_q))
                   && !(mem_resp_valid && line_of(miss_addr) == line_of(mem_resp_addr))
                   && merge_ok;
  assign alloc       = miss_valid && miss_ready && !active_hit;
  assign evict_ready = !ev_valid_q;

  // Request mux: writeback has priority, then the lowest-index pending miss.
  always_comb begin
    mem_req_valid     = 1'b0;
    mem_req_addr      = '0;
    mem_req_data      = '0;
    mem_req_store     = 1'b0;
    mem_req_writeback = 1'b0;
    if (ev_valid_q) begin
      mem_req_valid     = 1'b1;
      mem_req_addr      = ev_addr_q;
      mem_req_data      = ev_data_q;
      mem_req_writeback = 1'b1;
    end else if (pend_found) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = addr_q[pend_idx];
      mem_req_store = store_q[pend_idx];
      if (store_q[pend_idx])
        mem_req_data[31:0] = sdata_q[pend_idx];
    end
  end

  assign xfer = mem_req_valid && !mem_full;

  // Next state: response retire, request transfer, eviction load, miss allocation.
  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      st_d[i]    = st_q[i];
      addr_d[i]  = addr_q[i];
      store_d[i] = store_q[i];
      sdata_d[i] = sdata_q[i];
    end
    ev_valid_d   = ev_valid_q;
    ev_addr_d    = ev_addr_q;
    ev_data_d    = ev_data_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    resp_err_d   = resp_err_q;
    if (mem_resp_valid) begin
      if (resp_hit) begin
        st_d[resp_idx] = ST_FREE;
        fill_valid_d   = 1'b1;
        fill_addr_d    = line_of(mem_resp_addr);
        fill_data_d    = mem_resp_data;
      end else begin
        resp_err_d = 1'b1;
      end
    end
    if (xfer) begin
      if (ev_valid_q) ev_valid_d = 1'b0;
      else            st_d[pend_idx] = ST_WAIT;
    end
    if (evict_valid && evict_ready) begin
      ev_valid_d = 1'b1;
      ev_addr_d  = evict_addr;
      ev_data_d  = evict_data;
    end
    if (alloc) begin
      st_d[free_idx]    = ST_PEND;
      addr_d[free_idx]  = miss_addr;
      store_d[free_idx] = miss_store;
      sdata_d[free_idx] = miss_store_data;
    end
  end

  // Control and output registers; reset drops every in-flight entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_MSHR; i++) st_q[i] <= ST_FREE;
      ev_valid_q   <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) st_q[i] <= st_d[i];
      ev_valid_q   <= ev_valid_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Payload registers; only meaningful while their valid/state says so.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_MSHR; i++) begin
      addr_q[i]  <= addr_d[i];
      store_q[i] <= store_d[i];
      sdata_q[i] <= sdata_d[i];
    end
    ev_addr_q <= ev_addr_d;
    ev_data_q <= ev_data_d;
  end

  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;
  assign fill_data  = fill_data_q;
  assign resp_err   = resp_err_q;
endmodule
